// File: rtl/tlc_lamp_monitor.sv
// tlc_lamp_monitor: decodes the six lamp levels back into the controller phase and reports lamp,
// sequence and dwell faults. Dwell exit/overrun checks are built only with TLC_MON_DWELL_CHECK_EN.
module tlc_lamp_monitor #(
  parameter int DWELL0 = 3,
  parameter int DWELL1 = 1,
  parameter int DWELL2 = 5,
  parameter int DWELL3 = 1,
  parameter int DWELL4 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mr,
  input  logic       mg,
  input  logic       my,
  input  logic       sr,
  input  logic       sg,
  input  logic       sy,
  input  logic       clr_faults,
  output logic [2:0] phase,
  output logic       phase_valid,
  output logic [3:0] dwell,
  output logic       flt_lamp,
  output logic       flt_seq,
  output logic       flt_dwell,
  output logic       stk_lamp,
  output logic       stk_seq,
  output logic       stk_dwell,
  output logic [7:0] fault_count
);

  typedef enum logic [2:0] {
    PH_MR_SG   = 3'd0,
    PH_MR_SY   = 3'd1,
    PH_MG_SR   = 3'd2,
    PH_MY_SR   = 3'd3,
    PH_ALL_RED = 3'd4,
    PH_FLASH   = 3'd5,
    PH_UNKNOWN = 3'd7
  } phase_e;

  // Lamp vector order is {mr, my, mg, sr, sy, sg}.
  localparam logic [5:0] LAMP_MR_SG = 6'b100001;
  localparam logic [5:0] LAMP_MR_SY = 6'b100010;
  localparam logic [5:0] LAMP_MG_SR = 6'b001100;
  localparam logic [5:0] LAMP_MY_SR = 6'b010100;
  localparam logic [5:0] LAMP_MR_SR = 6'b100100;
  localparam logic [5:0] LAMP_MY_SY = 6'b010010;

  if (DWELL0 < 1 || DWELL0 > 15 || DWELL1 < 1 || DWELL1 > 15 || DWELL2 < 1 || DWELL2 > 15 ||
      DWELL3 < 1 || DWELL3 > 15 || DWELL4 < 1 || DWELL4 > 15) begin : g_dwellRange
    $error("tlc_lamp_monitor: every DWELLn must lie in 1..15");
  end

  logic       r_tickQ;
  logic [5:0] r_lampQ;
  logic       r_inValid;
  phase_e     r_phase;
  phase_e     w_phaseNext;
  phase_e     w_decPhase;
  phase_e     w_seqNext;
  logic       w_decValid;
  logic       w_legal;
  logic [3:0] r_dwell;
  logic [3:0] w_dwellNext;
  logic       r_fltLamp, r_fltSeq, r_fltDwell;
  logic       w_fltLampNext, w_fltSeqNext, w_fltDwellNext;
  logic       r_stkLamp, r_stkSeq, r_stkDwell;
  logic       w_anyFault;
  logic [7:0] r_faultCount;
  logic       w_exitFault;
  logic       w_overrunHit;

  // r_inValid keeps the cleared input stage from being decoded as a bad lamp pattern after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tickQ   <= 1'b0;
      r_lampQ   <= 6'd0;
      r_inValid <= 1'b0;
    end else begin
      r_tickQ   <= tick;
      r_lampQ   <= {mr, my, mg, sr, sy, sg};
      r_inValid <= 1'b1;
    end
  end

  always_comb begin
    w_decPhase = PH_UNKNOWN;
    w_decValid = 1'b1;
    case (r_lampQ)
      LAMP_MR_SG: w_decPhase = PH_MR_SG;
      LAMP_MR_SY: w_decPhase = PH_MR_SY;
      LAMP_MG_SR: w_decPhase = PH_MG_SR;
      LAMP_MY_SR: w_decPhase = PH_MY_SR;
      LAMP_MR_SR: w_decPhase = PH_ALL_RED;
      LAMP_MY_SY: w_decPhase = PH_FLASH;
      default:    w_decValid = 1'b0;
    endcase
  end

  always_comb begin
    w_seqNext = PH_UNKNOWN;
    case (r_phase)
      PH_MR_SG:   w_seqNext = PH_MR_SY;
      PH_MR_SY:   w_seqNext = PH_MG_SR;
      PH_MG_SR:   w_seqNext = PH_MY_SR;
      PH_MY_SR:   w_seqNext = PH_ALL_RED;
      PH_ALL_RED: w_seqNext = PH_MR_SG;
      default:    w_seqNext = PH_UNKNOWN;
    endcase
    w_legal = (w_decPhase == PH_FLASH) || (r_phase == PH_FLASH) || (w_decPhase == w_seqNext);
  end

`ifdef TLC_MON_DWELL_CHECK_EN
  logic [3:0] w_limit;
  logic       w_checked;
  logic       w_visitEnd;
  logic       r_overrun;

  always_comb begin
    w_limit = 4'd0;
    case (r_phase)
      PH_MR_SG:   w_limit = 4'(DWELL0);
      PH_MR_SY:   w_limit = 4'(DWELL1);
      PH_MG_SR:   w_limit = 4'(DWELL2);
      PH_MY_SR:   w_limit = 4'(DWELL3);
      PH_ALL_RED: w_limit = 4'(DWELL4);
      default:    w_limit = 4'd0;
    endcase
  end

  assign w_checked    = (r_phase != PH_FLASH) && (r_phase != PH_UNKNOWN);
  assign w_exitFault  = w_checked && !r_overrun && (r_dwell != w_limit);
  assign w_overrunHit = w_checked && r_tickQ && !r_overrun && (r_dwell == w_limit);
  assign w_visitEnd   = r_inValid && (!w_decValid || (r_phase == PH_UNKNOWN) || (w_decPhase != r_phase));

  // An overrun is reported once per visit and then masks that visit's exit check.
  always_ff @(posedge clk) begin
    if (reset || w_visitEnd) begin
      r_overrun <= 1'b0;
    end else if (w_overrunHit) begin
      r_overrun <= 1'b1;
    end
  end
`else
  assign w_exitFault  = 1'b0;
  assign w_overrunHit = 1'b0;
`endif

  always_comb begin
    w_phaseNext    = r_phase;
    w_dwellNext    = r_dwell;
    w_fltLampNext  = 1'b0;
    w_fltSeqNext   = 1'b0;
    w_fltDwellNext = 1'b0;
    if (r_inValid) begin
      if (!w_decValid) begin
        w_phaseNext   = PH_UNKNOWN;
        w_dwellNext   = 4'd0;
        w_fltLampNext = 1'b1;
      end else if (r_phase == PH_UNKNOWN) begin
        w_phaseNext = w_decPhase;
        w_dwellNext = 4'd0;
      end else if (w_decPhase != r_phase) begin
        w_phaseNext    = w_decPhase;
        w_dwellNext    = 4'd0;
        w_fltSeqNext   = !w_legal;
        w_fltDwellNext = w_exitFault;
      end else begin
        if (r_tickQ && (r_dwell != 4'd15)) begin
          w_dwellNext = r_dwell + 4'd1;
        end
        w_fltDwellNext = w_overrunHit;
      end
    end
  end

  assign w_anyFault = w_fltLampNext | w_fltSeqNext | w_fltDwellNext;

  // A fault arriving with clr_faults wins: stickies set and the count restarts at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase      <= PH_UNKNOWN;
      r_dwell      <= 4'd0;
      r_fltLamp    <= 1'b0;
      r_fltSeq     <= 1'b0;
      r_fltDwell   <= 1'b0;
      r_stkLamp    <= 1'b0;
      r_stkSeq     <= 1'b0;
      r_stkDwell   <= 1'b0;
      r_faultCount <= 8'd0;
    end else begin
      r_phase    <= w_phaseNext;
      r_dwell    <= w_dwellNext;
      r_fltLamp  <= w_fltLampNext;
      r_fltSeq   <= w_fltSeqNext;
      r_fltDwell <= w_fltDwellNext;
      r_stkLamp  <= (r_stkLamp & ~clr_faults) | w_fltLampNext;
      r_stkSeq   <= (r_stkSeq & ~clr_faults) | w_fltSeqNext;
      r_stkDwell <= (r_stkDwell & ~clr_faults) | w_fltDwellNext;
      if (w_anyFault) begin
        if (clr_faults) begin
          r_faultCount <= 8'd1;
        end else if (r_faultCount != 8'd255) begin
          r_faultCount <= r_faultCount + 8'd1;
        end
      end else if (clr_faults) begin
        r_faultCount <= 8'd0;
      end
    end
  end

  assign phase       = r_phase;
  assign phase_valid = (r_phase != PH_UNKNOWN);
  assign dwell       = r_dwell;
  assign flt_lamp    = r_fltLamp;
  assign flt_seq     = r_fltSeq;
  assign flt_dwell   = r_fltDwell;
  assign stk_lamp    = r_stkLamp;
  assign stk_seq     = r_stkSeq;
  assign stk_dwell   = r_stkDwell;
  assign fault_count = r_faultCount;

endmodule

// File: doc/tlc_lamp_monitor.md
# tlc_lamp_monitor

Receive-side checker for the traffic-light controller's six lamp outputs. It samples the main/side red/yellow/green lamps and decodes them back into the controller's phase code. It then checks every phase change against the legal sequence and the configured dwell times, and reports pulsed and sticky fault flags plus a saturating fault counter. It sits beside the controller, on the lamp driver side, and drives a supervisor or LED fault panel.

## Interface
- `DWELL0`, default 3: ticks expected in phase 0 (main red, side green).
- `DWELL1`, default 1: ticks expected in phase 1 (main red, side yellow).
- `DWELL2`, default 5: ticks expected in phase 2 (main green, side red).
- `DWELL3`, default 1: ticks expected in phase 3 (main yellow, side red).
- `DWELL4`, default 4: ticks expected in phase 4 (all red).
- All DWELLn are legal in the range 1..15.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `tick` in 1: the controller's count-enable pulse, one cycle wide.
- `mr`, `mg`, `my`, `sr`, `sg`, `sy` in 1 each: lamp levels.
- `clr_faults` in 1: clears the sticky flags and `fault_count`.
- `phase` out 3: decoded current phase; 7 means unknown.
- `phase_valid` out 1: `phase` holds a legal code 0..5.
- `dwell` out 4: ticks counted in the current phase.
- `flt_lamp`, `flt_seq`, `flt_dwell` out 1 each: one-cycle fault pulses.
- `stk_lamp`, `stk_seq`, `stk_dwell` out 1 each: sticky copies of the pulses.
- `fault_count` out 8: number of cycles with any fault pulse, saturating at 255.

## Operation
- **Input stage.** `tick` and the six lamps are registered into one input stage, `tick_q` and `lamp_q`, and all logic works from that stage.
- **Lamp decode** of {mr,my,mg,sr,sy,sg}:
  - 0 = MR+SG
  - 1 = MR+SY
  - 2 = MG+SR
  - 3 = MY+SR
  - 4 = MR+SR
  - 5 = MY+SY (flash)
  - Every other pattern is invalid.
- **Invalid pattern.**
  - Pulse `flt_lamp`.
  - Set `phase` = 7 and `phase_valid` = 0.
  - Clear `dwell` to 0.
  - Re-assert `flt_lamp` on every cycle the pattern stays invalid.
- **Resync.** A valid decode while `phase` = 7 (after reset or after an invalid pattern) loads the phase with no sequence or dwell check.
- **Legal transitions:** 0→1, 1→2, 2→3, 3→4, 4→0, any→5, and 5→any valid phase.
  - Any other change pulses `flt_seq`.
  - The new phase is adopted regardless.
- **Dwell counting.**
  - `dwell` increments on `tick_q` while the phase is unchanged, saturating at 15.
  - On a phase change, `dwell` loads 0.
- **Dwell check**, applied only to exits from phases 0..4:
  - Exit with `dwell` ≠ DWELLn pulses `flt_dwell`.
  - Overrun: `tick_q` while `dwell` == DWELLn pulses `flt_dwell` once per phase visit. The exit check is then suppressed for that visit.
  - Phase 5 is never dwell-checked.
- **Sticky flags.** Each `stk_*` flag sets on its pulse. `clr_faults` clears all `stk_*` and `fault_count`.
  - If `clr_faults` coincides with a fault, the fault wins: the sticky flag is set and `fault_count` = 1.
- **Fault counter.** `fault_count` adds 1 per cycle in which any `flt_*` is high, even if several are high at once, and saturates at 255.

## Timing
- Reset values: `phase` = 7, `phase_valid` = 0, `dwell` = 0, all `flt_*`/`stk_*` = 0, `fault_count` = 0, input stage cleared.
- Latency from a lamp change at the input to `phase`/`flt_*` is 2 clocks: input register, then decode/check register.
- `flt_*`, `stk_*` and `fault_count` update on the same edge as `phase`.
- `tick` to `dwell` has the same 2-clock latency.
- A controller tick that ends a phase is counted in the old phase. The lamps change one cycle after the tick, so `tick_q` precedes the changed `lamp_q` by one cycle.
- `reset` mid-phase returns all outputs to their reset values on the next edge. The first valid pattern after reset is a resync.

## Configuration
- Macro: `TLC_MON_DWELL_CHECK_EN`.
- Defined: dwell exit and overrun checks are active, and `flt_dwell`/`stk_dwell` behave as specified above.
- Undefined:
  - The checker logic is removed and `flt_dwell`/`stk_dwell` are tied to 0.
  - The `dwell` counter output is still present and counts as described.

## Test plan
- **Normal cycle:** after reset, lamps step through 0,1,2,3,4,0 with 3,1,5,1,4 ticks per phase → `phase` follows with 2-clock latency, no `flt_*`, `fault_count` = 0.
- **Illegal sequence:** lamps jump 0→2 after 3 ticks → `flt_seq` high for 1 cycle, `stk_seq` = 1, `fault_count` = 1, `phase` = 2.
- **Dwell:**
  - Phase 2 exited after 4 ticks → `flt_dwell` on exit, `fault_count` = 1.
  - Phase 2 held for 7 ticks → one `flt_dwell` on the 6th tick and none on exit.
  - With the macro undefined, both cases give no `flt_dwell`.
- **Bad lamps:** MG and SG both on for 3 cycles → `flt_lamp` for 3 cycles, `phase` = 7, `fault_count` = 3. The next valid pattern resyncs with no `flt_seq`.
- **Flash and clear:**
  - Any phase →5 and 5→3 → no faults.
  - 300 consecutive invalid cycles → `fault_count` = 255.
  - `clr_faults` coincident with `flt_lamp` → `stk_lamp` = 1, `fault_count` = 1.
